oscillator_phase_gen: RTL

- Phase sequencer that drives the waveform shapers (triangle, saw, square) with an oscillator_state_t half-cycle flag and a long_percent_t phase.
- Advances once per audio sample strobe by a frequency-derived increment.
- Toggles FRONT/BACK on each half-cycle overflow and flags completed periods.
- Sits between the note/frequency decode stage and the shaper bank, one instance per voice.

---
 rtl/oscillator_phase_gen.sv | 94 +++++++++
 1 files changed

// File: rtl/oscillator_phase_gen.sv
// Per-voice phase sequencer: advances a half-cycle phase accumulator on each
// audio sample strobe and toggles FRONT/BACK on every half-cycle overflow.

typedef enum logic {
  FRONT = 1'b0,
  BACK  = 1'b1
} oscillator_state_t;

module oscillator_phase_gen #(
  parameter int PHASE_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   sample_tick,
  input  logic                   enable,
  input  logic                   restart,
  input  logic [PHASE_WIDTH-1:0] increment,
  output oscillator_state_t      state,
  output logic [PHASE_WIDTH-1:0] phase,
  output logic                   sample_valid,
  output logic                   period_wrap,
  output logic [1:0]             fsm_dbg
);

  // START is the running state that still owes the start-of-note frame.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } fsm_t;

  fsm_t                   fsm_q, fsm_d;
  oscillator_state_t      state_d;
  logic [PHASE_WIDTH-1:0] phase_d;
  logic                   valid_d;
  logic                   wrap_d;
  logic [PHASE_WIDTH:0]   sum;

  assign sum     = {1'b0, phase} + {1'b0, increment};
  assign fsm_dbg = fsm_q;

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state;
    phase_d = phase;
    valid_d = sample_tick;
    wrap_d  = 1'b0;
    if (!enable) begin
      fsm_d   = IDLE;
      state_d = FRONT;
      phase_d = '0;
    end else if (restart) begin
      state_d = FRONT;
      phase_d = '0;
      if (sample_tick) begin
        fsm_d = RUN;
      end else if (fsm_q == IDLE) begin
        fsm_d = START;
      end
    end else if (sample_tick) begin
      if (fsm_q == RUN) begin
        phase_d = sum[PHASE_WIDTH-1:0];
        if (sum[PHASE_WIDTH]) begin
          state_d = (state == FRONT) ? BACK : FRONT;
          wrap_d  = (state == BACK);
        end
      end else begin
        // First tick after enable: emit phase 0 without advancing.
        fsm_d   = RUN;
        state_d = FRONT;
        phase_d = '0;
      end
    end else if (fsm_q == IDLE) begin
      fsm_d = START;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm_q        <= IDLE;
      state        <= FRONT;
      phase        <= '0;
      sample_valid <= 1'b0;
      period_wrap  <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      state        <= state_d;
      phase        <= phase_d;
      sample_valid <= valid_d;
      period_wrap  <= wrap_d;
    end
  end

endmodule
